// File: rtl/fetch_instr_queue_pkg.sv
// Shared types and constants for the per-thread fetch-to-decode instruction queue.
// Also hosts the round-robin arbiter used to pick the issuing thread.
package fetch_instr_queue_pkg;

   localparam int THR_PER_CORE       = 4;
   localparam int THR_PER_CORE_WIDTH = $clog2(THR_PER_CORE);
   localparam int INSTR_WIDTH        = 32;
   localparam int PC_WIDTH           = 32;

   typedef enum logic {
      Single_Threaded = 1'b0,
      Multi_Threaded  = 1'b1
   } multithreading_mode_t;

   typedef struct packed {
      logic itlb_miss;
      logic bus_error;
   } fetch_xcpt_t;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]    pc;
      fetch_xcpt_t            xcpt;
   } fetch_queue_entry_t;

   // One-hot grant of the first requester at or after prio, wrapping around.
   function automatic logic [THR_PER_CORE-1:0] arb_rr(
      input logic [THR_PER_CORE-1:0]       req,
      input logic [THR_PER_CORE_WIDTH-1:0] prio
   );
      logic [THR_PER_CORE-1:0]       grant;
      logic [THR_PER_CORE_WIDTH-1:0] idx;
      grant = '0;
      for (int i = THR_PER_CORE - 1; i >= 0; i--) begin
         idx = prio + THR_PER_CORE_WIDTH'(i);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/fetch_instr_queue_thread_fifo.sv
// Single-thread instruction FIFO: push/pop/flush with count and head outputs.
// A push into a full queue is only accepted when the same cycle also pops.
module instr_thread_fifo
   import fetch_instr_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_queue_entry_t       push_entry,
   output fetch_queue_entry_t       head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_queue_entry_t mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic               full;
   logic               do_pop;
   logic               do_push;

   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !flush && (count != '0);
   assign do_push = push && !flush && (!full || do_pop);
   assign drop    = push && !flush && full && !do_pop;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset; only entries below count are ever read out.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

endmodule

// File: rtl/fetch_instr_queue.sv
// Per-thread instruction queues between fetch and decode, with round-robin issue
// of one instruction per cycle, stall_fetch back-pressure and per-thread flush.
module fetch_instr_queue
   import fetch_instr_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SKID  = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  multithreading_mode_t          mt_mode,
   input  logic                          fetch_instr_valid,
   input  logic [INSTR_WIDTH-1:0]        fetch_instr_data,
   input  logic [PC_WIDTH-1:0]           fetch_instr_pc,
   input  logic [THR_PER_CORE_WIDTH-1:0] fetch_thread_id,
   input  fetch_xcpt_t                   fetch_xcpt,
   input  logic [THR_PER_CORE-1:0]       flush,
   input  logic [THR_PER_CORE-1:0]       stall_decode,
   output logic [THR_PER_CORE-1:0]       stall_fetch,
   output logic                          decode_instr_valid,
   output logic [INSTR_WIDTH-1:0]        decode_instr_data,
   output logic [PC_WIDTH-1:0]           decode_instr_pc,
   output logic [THR_PER_CORE_WIDTH-1:0] decode_thread_id,
   output fetch_xcpt_t                   decode_xcpt,
   output logic                          overflow_error
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_queue_entry_t              push_entry;
   fetch_queue_entry_t              head [THR_PER_CORE];
   logic [CNT_W-1:0]                count [THR_PER_CORE];
   logic [THR_PER_CORE-1:0]         push;
   logic [THR_PER_CORE-1:0]         eligible;
   logic [THR_PER_CORE-1:0]         grant;
   logic [THR_PER_CORE-1:0]         drop;
   logic [THR_PER_CORE_WIDTH-1:0]   push_tid;
   logic [THR_PER_CORE_WIDTH-1:0]   grant_idx;
   logic [THR_PER_CORE_WIDTH-1:0]   rr_ptr;
   logic                            any_grant;

   assign push_tid   = (mt_mode == Single_Threaded) ? '0 : fetch_thread_id;
   assign push_entry = '{instr: fetch_instr_data, pc: fetch_instr_pc, xcpt: fetch_xcpt};

   for (genvar t = 0; t < THR_PER_CORE; t++) begin : g_thread
      assign push[t]        = fetch_instr_valid && (push_tid == THR_PER_CORE_WIDTH'(t));
      assign eligible[t]    = (count[t] != '0) && !stall_decode[t] && !flush[t] &&
                              ((mt_mode == Multi_Threaded) || (t == 0));
      assign stall_fetch[t] = (count[t] >= CNT_W'(DEPTH - SKID));

      instr_thread_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clock      (clock),
         .reset      (reset),
         .push       (push[t]),
         .pop        (grant[t]),
         .flush      (flush[t]),
         .push_entry (push_entry),
         .head       (head[t]),
         .count      (count[t]),
         .drop       (drop[t])
      );
   end

   // rr_ptr names the thread with highest priority this cycle.
   always_comb begin
      grant     = arb_rr(eligible, rr_ptr);
      grant_idx = '0;
      for (int t = 0; t < THR_PER_CORE; t++) begin
         if (grant[t]) begin
            grant_idx = THR_PER_CORE_WIDTH'(t);
         end
      end
   end

   assign any_grant = |grant;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr             <= '0;
         decode_instr_valid <= 1'b0;
         decode_instr_data  <= '0;
         decode_instr_pc    <= '0;
         decode_thread_id   <= '0;
         decode_xcpt        <= '0;
         overflow_error     <= 1'b0;
      end else begin
         decode_instr_valid <= any_grant;
         if (any_grant) begin
            rr_ptr            <= grant_idx + THR_PER_CORE_WIDTH'(1);
            decode_instr_data <= head[grant_idx].instr;
            decode_instr_pc   <= head[grant_idx].pc;
            decode_thread_id  <= grant_idx;
            decode_xcpt       <= head[grant_idx].xcpt;
         end
         if (|drop) begin
            overflow_error <= 1'b1;
         end
      end
   end

endmodule
